uart_rx: RTL
============

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 30_000_000, clock frequency in Hz (informational).
REQ-002 SHALL have parameter CYCLES_PER_BIT, default 3125, clock cycles per bit period (30 MHz / 9600 baud); legal values are >= 4.
REQ-003 SHALL have port clk, input, 1, single clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, reset, asynchronous and active-low.
REQ-005 SHALL have port rx, input, 1, asynchronous serial line; idles high.
REQ-006 SHALL have port rx_data, output, 8, last received data byte.
REQ-007 SHALL have port rx_valid, output, 1, one-cycle pulse when a frame is received with no errors.
REQ-008 SHALL have port parity_err, output, 1, one-cycle pulse when the received parity bit is wrong.
REQ-009 SHALL have port frame_err, output, 1, one-cycle pulse when the stop bit is sampled low.
REQ-010 SHALL have port busy, output, 1, high whenever the FSM is not in IDLE.

Function
REQ-011 SHALL accept this frame format: 1 start bit (0), 8 data bits LSB first, 1 odd-parity bit, 1 stop bit (1).
REQ-012 SHALL pass rx through a 2-flop synchronizer whose flops reset to 1; all logic uses the synchronized value rx_s.
REQ-013 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP and WAIT_IDLE; any unused encoding SHALL go to IDLE.
REQ-014 IDLE: on a falling edge of rx_s (previous 1, current 0) SHALL go to START and clear the baud counter.
REQ-015 START: after CYCLES_PER_BIT/2 cycles (integer division), SHALL sample rx_s; if 0, go to DATA and restart the counter; if 1 (glitch), return to IDLE with no output pulse.
REQ-016 DATA: SHALL sample every CYCLES_PER_BIT cycles and shift each sample into bit position 0..7 in order; after the 8th sample, go to PARITY.
REQ-017 PARITY: SHALL sample one bit after CYCLES_PER_BIT cycles; the parity check passes when XOR of the 8 data bits and the parity bit equals 1.
REQ-018 STOP: SHALL sample rx_s after CYCLES_PER_BIT cycles, i.e. at the stop-bit midpoint.
REQ-019 On the clock after the stop sample, SHALL load rx_data with the shifted byte regardless of errors.
REQ-020 On that same clock, SHALL pulse rx_valid only if parity passed and the stop bit is 1; otherwise it SHALL pulse parity_err and/or frame_err as applicable.
REQ-021 After STOP: if the stop bit is 1, SHALL go to IDLE; if 0, SHALL go to WAIT_IDLE and stay there until rx_s is 1, so a break condition never starts a new frame.
REQ-022 rx_valid, parity_err and frame_err SHALL each be high for exactly one clock per frame; rx_valid SHALL never be high in the same cycle as either error flag.
REQ-023 rx_data SHALL hold its value until the next frame completes.
REQ-024 busy SHALL rise on the clock that enters START and fall on the clock that returns to IDLE.
REQ-025 Line activity during DATA, PARITY or STOP SHALL NOT restart the frame; only the midpoint samples are used.
REQ-026 The baud counter SHALL be $clog2(CYCLES_PER_BIT)+1 bits wide and SHALL hold at 0 in IDLE and WAIT_IDLE.
REQ-027 Back-to-back frames SHALL be received: a falling edge seen in IDLE on the cycle right after returning from STOP SHALL start the next frame.

Reset
REQ-028 While rst_n is low, regardless of clk, the block SHALL set: FSM to IDLE; counter, shift register and rx_data to 0; rx_valid, parity_err, frame_err and busy to 0; synchronizer flops to 1.
REQ-029 An assertion of rst_n in the middle of a frame SHALL discard the partial frame with no output pulse; after release, reception SHALL resume at the next falling edge of rx_s.

Verification (CYCLES_PER_BIT=16)
REQ-030 Send 0xA5 with parity 1 and stop 1 -> rx_data=0xA5, one rx_valid pulse, no error pulses, busy low afterwards.
REQ-031 Send 0xA5 with parity 0 -> rx_data=0xA5, parity_err pulse, rx_valid stays 0.
REQ-032 Send 0x3C with parity 1 and stop bit 0, then hold rx low for 40 cycles -> frame_err pulse; FSM stays in WAIT_IDLE with busy high until rx rises, and no second frame is started.
REQ-033 Pulse rx low for 4 cycles while idle -> FSM returns to IDLE with no pulses; busy is high for fewer than 10 cycles.
REQ-034 Send 0x00 (parity 1) and 0xFF (parity 1) back-to-back with no idle gap -> two rx_valid pulses with rx_data 0x00 then 0xFF.
REQ-035 Assert rst_n low after the 4th data bit of a frame, release it, then send 0x5A -> only one rx_valid pulse, with rx_data=0x5A.

Source files
------------

// File: rtl/uart_rx.sv
// UART receiver: 8 data bits LSB first, odd parity, one stop bit.
// Midpoint sampling off a synchronized line, one-cycle result pulses.
module uart_rx #(
    parameter int CLK_FREQ       = 30_000_000,
    parameter int CYCLES_PER_BIT = 3125
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       parity_err,
    output logic       frame_err,
    output logic       busy
);

    localparam int CW = $clog2(CYCLES_PER_BIT) + 1;
    localparam logic [CW-1:0] HALF = CW'(CYCLES_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL = CW'(CYCLES_PER_BIT - 1);

    if (CYCLES_PER_BIT < 4) begin : g_bad_cpb
        $error("CYCLES_PER_BIT must be at least 4");
    end
    if (CLK_FREQ < CYCLES_PER_BIT) begin : g_bad_freq
        $error("CLK_FREQ below one bit period per second");
    end

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        PARITY    = 3'd3,
        STOP      = 3'd4,
        WAIT_IDLE = 3'd5
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [7:0]      shift_q, shift_d;
    logic [2:0]      bits_q, bits_d;
    logic            par_q, par_d;
    logic [7:0]      data_q, data_d;
    logic            valid_q, valid_d;
    logic            perr_q, perr_d;
    logic            ferr_q, ferr_d;
    logic            busy_q, busy_d;
    logic            rx_meta_q, rx_s_q, rx_prev_q;
    logic            par_ok;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            rx_prev_q <= 1'b1;
            state_q   <= IDLE;
            cnt_q     <= '0;
            shift_q   <= '0;
            bits_q    <= '0;
            par_q     <= 1'b0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            perr_q    <= 1'b0;
            ferr_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
            rx_prev_q <= rx_s_q;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            shift_q   <= shift_d;
            bits_q    <= bits_d;
            par_q     <= par_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            perr_q    <= perr_d;
            ferr_q    <= ferr_d;
            busy_q    <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        bits_d  = bits_q;
        par_d   = par_q;
        data_d  = data_q;
        valid_d = 1'b0;
        perr_d  = 1'b0;
        ferr_d  = 1'b0;
        par_ok  = ^{shift_q, par_q};
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (rx_prev_q && !rx_s_q) state_d = START;
            end
            START: begin
                if (cnt_q == HALF) begin
                    cnt_d   = '0;
                    bits_d  = '0;
                    state_d = rx_s_q ? IDLE : DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DATA: begin
                if (cnt_q == FULL) begin
                    cnt_d   = '0;
                    shift_d = {rx_s_q, shift_q[7:1]};
                    bits_d  = bits_q + 3'd1;
                    if (bits_q == 3'd7) state_d = PARITY;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            PARITY: begin
                if (cnt_q == FULL) begin
                    cnt_d   = '0;
                    par_d   = rx_s_q;
                    state_d = STOP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            STOP: begin
                if (cnt_q == FULL) begin
                    cnt_d   = '0;
                    data_d  = shift_q;
                    valid_d = par_ok && rx_s_q;
                    perr_d  = !par_ok;
                    ferr_d  = !rx_s_q;
                    // a low stop bit may be a break; wait for the line to recover
                    state_d = rx_s_q ? IDLE : WAIT_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            WAIT_IDLE: begin
                cnt_d = '0;
                if (rx_s_q) state_d = IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    assign rx_data    = data_q;
    assign rx_valid   = valid_q;
    assign parity_err = perr_q;
    assign frame_err  = ferr_q;
    assign busy       = busy_q;

endmodule
